// File: rtl/zone_pkg.sv
// zone_pkg: shared types and sizing helpers
// for the multi-zone centroid tracker.
package zone_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    DIV_X,
    LOAD_Y,
    DIV_Y,
    PUBLISH
  } state_e;

  function automatic int cnt_w(input int zone_w, input int v_max);
    return $clog2(zone_w * v_max + 1);
  endfunction

  function automatic int sum_w(input int coord_w, input int zone_w,
                               input int v_max);
    return coord_w + cnt_w(zone_w, v_max);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned zone_of(input int unsigned x,
                                          input int unsigned lg);
    return x >> lg;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring divider, one quotient bit per cycle.
// short_in selects the narrower quotient width and its shorter latency.
module serial_divider #(
  parameter int DVD_W = 29,
  parameter int DVS_W = 18,
  parameter int Q_W   = 11,
  parameter int SQ_W  = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             short_in,
  input  logic [DVD_W-1:0] dividend_in,
  input  logic [DVS_W-1:0] divisor_in,
  output logic             done_out,
  output logic [Q_W-1:0]   quot_out
);

  localparam int CW = (Q_W > 1) ? $clog2(Q_W) : 1;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [Q_W-1:0]   low_q, low_d;
  logic [Q_W-1:0]   quot_q, quot_d;
  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             ge;

  // Trial subtraction for the current quotient bit
  always_comb begin
    trial    = {rem_q, low_q[Q_W-1]};
    diff     = trial[DVS_W-1:0] - dvs_q;
    ge       = trial >= {1'b0, dvs_q};
    done_out = busy_q && (cnt_q == CW'(Q_W - 1));
    quot_out = {quot_q[Q_W-2:0], ge};
  end

  // Load on start; the short mode skips the leading always-zero bits
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    low_d  = low_q;
    quot_d = quot_q;
    if (start_in) begin
      busy_d = 1'b1;
      dvs_d  = divisor_in;
      quot_d = '0;
      if (short_in) begin
        rem_d = DVS_W'(dividend_in >> SQ_W);
        low_d = Q_W'(dividend_in[SQ_W-1:0]) << (Q_W - SQ_W);
        cnt_d = CW'(Q_W - SQ_W);
      end else begin
        rem_d = DVS_W'(dividend_in >> Q_W);
        low_d = dividend_in[Q_W-1:0];
        cnt_d = '0;
      end
    end else if (busy_q) begin
      rem_d  = ge ? diff : trial[DVS_W-1:0];
      low_d  = low_q << 1;
      quot_d = {quot_q[Q_W-2:0], ge};
      cnt_d  = cnt_q + CW'(1);
      if (done_out) busy_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      low_q  <= '0;
      quot_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      low_q  <= low_d;
      quot_q <= quot_d;
    end
  end

endmodule

// File: rtl/zone_centroid.sv
// zone_centroid: per-strip pixel accumulation and centroid
// computation with one shared serial divider per frame.
module zone_centroid
  import zone_pkg::*;
#(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int ZONES     = 4,
  parameter int ZONE_W    = 256,
  parameter int V_MAX     = 768,
  parameter int MIN_COUNT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [H_WIDTH-1:0]         x_in,
  input  logic [V_WIDTH-1:0]         y_in,
  input  logic                       valid_in,
  input  logic                       tabulate_in,
  output logic [ZONES*H_WIDTH-1:0]   x_out,
  output logic [ZONES*V_WIDTH-1:0]   y_out,
  output logic [ZONES-1:0]           present_out,
  output logic [idx_w(ZONES)-1:0]    dominant_out,
  output logic                       dominant_valid_out,
  output logic                       valid_out,
  output logic                       busy_out,
  output logic                       overrun_out
);

  localparam int  CNT_W   = cnt_w(ZONE_W, V_MAX);
  localparam int  SX_W    = sum_w(H_WIDTH, ZONE_W, V_MAX);
  localparam int  SY_W    = sum_w(V_WIDTH, ZONE_W, V_MAX);
  localparam int  ZW      = idx_w(ZONES);
  localparam int  LG      = $clog2(ZONE_W);
  localparam int  SPAN    = ZONES * ZONE_W;
  localparam bit  Y_SHORT = V_WIDTH <= H_WIDTH;
  localparam int  QL      = Y_SHORT ? H_WIDTH : V_WIDTH;
  localparam int  QS      = Y_SHORT ? V_WIDTH : H_WIDTH;
  localparam int  DVD_W   = QL + CNT_W;

  logic [H_WIDTH-1:0] s1_x_q;
  logic [V_WIDTH-1:0] s1_y_q;
  logic               s1_vld_q, s1_tab_q;

  logic [CNT_W-1:0]   cnt_q[ZONES], cnt_d[ZONES];
  logic [SX_W-1:0]    sx_q[ZONES], sx_d[ZONES];
  logic [SY_W-1:0]    sy_q[ZONES], sy_d[ZONES];
  logic [CNT_W-1:0]   shd_cnt_q[ZONES], shd_cnt_d[ZONES];
  logic [SX_W-1:0]    shd_sx_q[ZONES], shd_sx_d[ZONES];
  logic [SY_W-1:0]    shd_sy_q[ZONES], shd_sy_d[ZONES];
  logic [H_WIDTH-1:0] stg_x_q[ZONES], stg_x_d[ZONES];
  logic [V_WIDTH-1:0] stg_y_q[ZONES], stg_y_d[ZONES];

  logic [ZONES*H_WIDTH-1:0] xo_q, xo_d;
  logic [ZONES*V_WIDTH-1:0] yo_q, yo_d;
  logic [ZONES-1:0]         po_q, po_d;
  logic [ZW-1:0]            dom_q, dom_d;
  logic                     domv_q, domv_d;
  logic                     vo_q, vo_d;

  state_e        state_q, state_d;
  logic [ZW-1:0] zone_q, zone_d;

  logic             in_rng, snap, last_zone;
  logic [ZW-1:0]    pz;
  logic [ZONES-1:0] pres;
  logic [CNT_W-1:0] best_c;
  logic [ZW-1:0]    best_i;
  logic             best_v;
  logic             div_start, div_short, div_done, is_y;
  logic             cap_x, cap_y, publish;
  logic [DVD_W-1:0] dvd;
  logic [QL-1:0]    quot;

  assign busy_out           = state_q != IDLE;
  assign overrun_out        = s1_tab_q && (state_q != IDLE);
  assign x_out              = xo_q;
  assign y_out              = yo_q;
  assign present_out        = po_q;
  assign dominant_out       = dom_q;
  assign dominant_valid_out = domv_q;
  assign valid_out          = vo_q;

  // Live accumulators restart on every frame boundary, snapshot only when idle
  always_comb begin
    in_rng = 32'(s1_x_q) < 32'(SPAN);
    pz     = ZW'(zone_of(32'(s1_x_q), LG));
    snap   = s1_tab_q && (state_q == IDLE);
    for (int z = 0; z < ZONES; z++) begin
      cnt_d[z]     = s1_tab_q ? '0 : cnt_q[z];
      sx_d[z]      = s1_tab_q ? '0 : sx_q[z];
      sy_d[z]      = s1_tab_q ? '0 : sy_q[z];
      shd_cnt_d[z] = snap ? cnt_q[z] : shd_cnt_q[z];
      shd_sx_d[z]  = snap ? sx_q[z] : shd_sx_q[z];
      shd_sy_d[z]  = snap ? sy_q[z] : shd_sy_q[z];
    end
    if (s1_vld_q && in_rng) begin
      cnt_d[pz] = cnt_d[pz] + CNT_W'(1);
      sx_d[pz]  = sx_d[pz] + SX_W'(s1_x_q);
      sy_d[pz]  = sy_d[pz] + SY_W'(s1_y_q);
    end
  end

  // Presence and dominant zone from the frozen snapshot; ties keep the lower index
  always_comb begin
    best_c = '0;
    best_i = '0;
    best_v = 1'b0;
    for (int z = 0; z < ZONES; z++) begin
      pres[z] = shd_cnt_q[z] >= CNT_W'(MIN_COUNT);
      if (pres[z] && (!best_v || shd_cnt_q[z] > best_c)) begin
        best_v = 1'b1;
        best_c = shd_cnt_q[z];
        best_i = ZW'(z);
      end
    end
  end

  // FSM next state: per zone X then Y division, then publish
  always_comb begin
    state_d   = state_q;
    zone_d    = zone_q;
    last_zone = zone_q == ZW'(ZONES - 1);
    unique case (state_q)
      IDLE: begin
        zone_d = '0;
        if (s1_tab_q) state_d = LOAD_X;
      end
      LOAD_X: state_d = DIV_X;
      DIV_X:  if (div_done) state_d = LOAD_Y;
      LOAD_Y: state_d = DIV_Y;
      DIV_Y: begin
        if (div_done) begin
          if (last_zone) begin
            state_d = PUBLISH;
          end else begin
            state_d = LOAD_X;
            zone_d  = zone_q + ZW'(1);
          end
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: divider operands and capture strobes
  always_comb begin
    is_y      = state_q == LOAD_Y;
    div_start = (state_q == LOAD_X) || is_y;
    div_short = is_y == Y_SHORT;
    dvd       = is_y ? DVD_W'(shd_sy_q[zone_q])
                     : DVD_W'(shd_sx_q[zone_q]);
    cap_x     = (state_q == DIV_X) && div_done;
    cap_y     = (state_q == DIV_Y) && div_done;
    publish   = state_q == PUBLISH;
  end

  // Staging set; absent zones read as zero
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      stg_x_d[z] = stg_x_q[z];
      stg_y_d[z] = stg_y_q[z];
    end
    if (cap_x)
      stg_x_d[zone_q] = pres[zone_q] ? quot[H_WIDTH-1:0] : '0;
    if (cap_y)
      stg_y_d[zone_q] = pres[zone_q] ? quot[V_WIDTH-1:0] : '0;
  end

  // All outputs change together on publish
  always_comb begin
    xo_d   = xo_q;
    yo_d   = yo_q;
    po_d   = po_q;
    dom_d  = dom_q;
    domv_d = domv_q;
    vo_d   = publish;
    if (publish) begin
      for (int z = 0; z < ZONES; z++) begin
        xo_d[z*H_WIDTH +: H_WIDTH] = stg_x_q[z];
        yo_d[z*V_WIDTH +: V_WIDTH] = stg_y_q[z];
      end
      po_d   = pres;
      dom_d  = best_v ? best_i : '0;
      domv_d = best_v;
    end
  end

  serial_divider #(
    .DVD_W (DVD_W),
    .DVS_W (CNT_W),
    .Q_W   (QL),
    .SQ_W  (QS)
  ) u_div (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (div_start),
    .short_in    (div_short),
    .dividend_in (dvd),
    .divisor_in  (shd_cnt_q[zone_q]),
    .done_out    (div_done),
    .quot_out    (quot)
  );

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      zone_q  <= '0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
    end
  end

  // Input stage, accumulators, shadow, staging and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_tab_q <= 1'b0;
      for (int z = 0; z < ZONES; z++) begin
        cnt_q[z]     <= '0;
        sx_q[z]      <= '0;
        sy_q[z]      <= '0;
        shd_cnt_q[z] <= '0;
        shd_sx_q[z]  <= '0;
        shd_sy_q[z]  <= '0;
        stg_x_q[z]   <= '0;
        stg_y_q[z]   <= '0;
      end
      xo_q   <= '0;
      yo_q   <= '0;
      po_q   <= '0;
      dom_q  <= '0;
      domv_q <= 1'b0;
      vo_q   <= 1'b0;
    end else begin
      s1_x_q   <= x_in;
      s1_y_q   <= y_in;
      s1_vld_q <= valid_in;
      s1_tab_q <= tabulate_in;
      for (int z = 0; z < ZONES; z++) begin
        cnt_q[z]     <= cnt_d[z];
        sx_q[z]      <= sx_d[z];
        sy_q[z]      <= sy_d[z];
        shd_cnt_q[z] <= shd_cnt_d[z];
        shd_sx_q[z]  <= shd_sx_d[z];
        shd_sy_q[z]  <= shd_sy_d[z];
        stg_x_q[z]   <= stg_x_d[z];
        stg_y_q[z]   <= stg_y_d[z];
      end
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      po_q   <= po_d;
      dom_q  <= dom_d;
      domv_q <= domv_d;
      vo_q   <= vo_d;
    end
  end

endmodule

// File: tb/tb_zone_centroid.sv
// tb_zone_centroid: table-driven frames with a publish scoreboard,
// plus overrun and mid-sequence reset sequences.
module tb_zone_centroid;

  localparam int LAT = 95;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic        valid_in = 1'b0;
  logic        tabulate_in = 1'b0;
  logic [43:0] x_out;
  logic [39:0] y_out;
  logic [3:0]  present_out;
  logic [1:0]  dominant_out;
  logic        dominant_valid_out;
  logic        valid_out;
  logic        busy_out;
  logic        overrun_out;

  zone_centroid dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .x_in               (x_in),
    .y_in               (y_in),
    .valid_in           (valid_in),
    .tabulate_in        (tabulate_in),
    .x_out              (x_out),
    .y_out              (y_out),
    .present_out        (present_out),
    .dominant_out       (dominant_out),
    .dominant_valid_out (dominant_valid_out),
    .valid_out          (valid_out),
    .busy_out           (busy_out),
    .overrun_out        (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int b0x, b0y, b0w, b0h;
    bit omit;
    int b1x, b1y, b1w, b1h;
    int junk;
    bit tp;
    int tpx, tpy;
    logic [3:0]  p;
    logic [43:0] ex;
    logic [39:0] ey;
    logic [1:0]  dom;
    logic        dv;
  } vec_t;

  typedef struct {
    logic [3:0]  p;
    logic [43:0] ex;
    logic [39:0] ey;
    logic [1:0]  dom;
    logic        dv;
    int          t;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_valid = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Publish monitor: pops the scoreboard on every valid_out
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid: got 1 required 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.t));
        chk("present", 64'(present_out), 64'(e.p));
        chk("x_out", 64'(x_out), 64'(e.ex));
        chk("y_out", 64'(y_out), 64'(e.ey));
        chk("dominant", 64'(dominant_out), 64'(e.dom));
        chk("dom_valid", 64'(dominant_valid_out), 64'(e.dv));
        chk("busy_at_valid", 64'(busy_out), 64'(0));
      end
    end
  end

  task automatic pix(input int x, input int y, input bit v, input bit t);
    @(posedge clk_in);
    #1;
    x_in        = 11'(x);
    y_in        = 10'(y);
    valid_in    = v;
    tabulate_in = t;
  endtask

  task automatic blob(input int x0, input int y0, input int w, input int h,
                      input bit omit);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        if (!(omit && xx == w - 1 && yy == h - 1))
          pix(x0 + xx, y0 + yy, 1'b1, 1'b0);
  endtask

  task automatic push_exp(input vec_t r, input int t);
    exp_t e;
    e.p = r.p; e.ex = r.ex; e.ey = r.ey;
    e.dom = r.dom; e.dv = r.dv; e.t = t;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk_in);
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL valid_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input int i);
    vec_t r = tbl[i];
    int t0;
    blob(r.b0x, r.b0y, r.b0w, r.b0h, r.omit);
    blob(r.b1x, r.b1y, r.b1w, r.b1h, 1'b0);
    for (int j = 0; j < r.junk; j++) pix(1024 + j, 300, 1'b1, 1'b0);
    pix(r.tpx, r.tpy, r.tp, 1'b1);
    t0 = cyc;
    push_exp(r, t0 + LAT);
    pix(0, 0, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("busy_t1", 64'(busy_out), 64'(0));
    @(posedge clk_in);
    @(negedge clk_in);
    chk("busy_t2", 64'(busy_out), 64'(1));
    wait_empty();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, 64'(x_out), 64'(0));
    chk({tag, "_y"}, 64'(y_out), 64'(0));
    chk({tag, "_present"}, 64'(present_out), 64'(0));
    chk({tag, "_dom"}, 64'(dominant_out), 64'(0));
    chk({tag, "_domv"}, 64'(dominant_valid_out), 64'(0));
    chk({tag, "_valid"}, 64'(valid_out), 64'(0));
    chk({tag, "_busy"}, 64'(busy_out), 64'(0));
    chk({tag, "_overrun"}, 64'(overrun_out), 64'(0));
  endtask

  initial begin
    int t0, nv0;
    // b0(x,y,w,h,omit) b1(x,y,w,h) junk tp(x,y) | p ex ey dom dv
    tbl[0] = '{0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0,
               4'b0000, {11'd0, 11'd0, 11'd0, 11'd0},
               {10'd0, 10'd0, 10'd0, 10'd0}, 2'd0, 1'b0};
    tbl[1] = '{100, 200, 10, 10, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0,
               4'b0001, {11'd0, 11'd0, 11'd0, 11'd104},
               {10'd0, 10'd0, 10'd0, 10'd204}, 2'd0, 1'b1};
    tbl[2] = '{300, 10, 8, 8, 1'b0, 600, 50, 7, 9, 0, 1'b0, 0, 0,
               4'b0010, {11'd0, 11'd0, 11'd303, 11'd0},
               {10'd0, 10'd0, 10'd13, 10'd0}, 2'd1, 1'b1};
    tbl[3] = '{248, 0, 16, 8, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0,
               4'b0011, {11'd0, 11'd0, 11'd259, 11'd251},
               {10'd0, 10'd0, 10'd3, 10'd3}, 2'd0, 1'b1};
    tbl[4] = '{512, 100, 10, 10, 1'b0, 1000, 5, 8, 8, 77, 1'b0, 0, 0,
               4'b1100, {11'd1003, 11'd516, 11'd0, 11'd0},
               {10'd8, 10'd104, 10'd0, 10'd0}, 2'd2, 1'b1};
    tbl[5] = '{0, 0, 8, 8, 1'b1, 0, 0, 0, 0, 0, 1'b1, 7, 7,
               4'b0000, {11'd0, 11'd0, 11'd0, 11'd0},
               {10'd0, 10'd0, 10'd0, 10'd0}, 2'd0, 1'b0};
    tbl[6] = '{0, 0, 8, 8, 1'b1, 0, 0, 0, 0, 0, 1'b0, 0, 0,
               4'b0001, {11'd0, 11'd0, 11'd0, 11'd3},
               {10'd0, 10'd0, 10'd0, 10'd3}, 2'd0, 1'b1};
    tbl[7] = '{0, 0, 8, 8, 1'b0, 800, 400, 9, 9, 0, 1'b0, 0, 0,
               4'b1001, {11'd804, 11'd0, 11'd0, 11'd3},
               {10'd404, 10'd0, 10'd0, 10'd3}, 2'd3, 1'b1};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_zero("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Overrun: second frame boundary 20 cycles after the first
    nv0 = n_valid;
    blob(100, 200, 10, 10, 1'b0);
    pix(0, 0, 1'b0, 1'b1);
    t0 = cyc;
    push_exp(tbl[1], t0 + LAT);
    repeat (19) pix(0, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b0, 1'b1);
    @(negedge clk_in);
    chk("overrun_t20", 64'(overrun_out), 64'(0));
    pix(0, 0, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("overrun_t21", 64'(overrun_out), 64'(1));
    chk("overrun_cycle", 64'(cyc), 64'(t0 + 21));
    pix(0, 0, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("overrun_t22", 64'(overrun_out), 64'(0));
    wait_empty();
    repeat (120) @(posedge clk_in);
    chk("overrun_single_valid", 64'(n_valid), 64'(nv0 + 1));

    // Reset in the middle of a divider sequence
    blob(300, 10, 8, 8, 1'b0);
    pix(0, 0, 1'b0, 1'b1);
    t0 = cyc;
    nv0 = n_valid;
    repeat (39) pix(0, 0, 1'b0, 1'b0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk_zero("midreset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (100) @(posedge clk_in);
    chk("midreset_no_valid", 64'(n_valid), 64'(nv0));
    run_vec(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/zone_centroid.md
# zone_centroid

Multi-zone centroid tracker for the video pipeline. It sits after the threshold stage on `clk_65mhz` and succeeds the single-blob center-of-mass block. The screen is split into `ZONES` vertical strips. For each strip the block accumulates thresholded-pixel counts and coordinate sums over a frame, then runs one shared serial divider to produce a per-zone centroid, a presence flag and a dominant-zone index. Downstream users are the game-state and key-input logic, which read one consistent result set per frame.

## Interface
Parameters:
- `H_WIDTH`, 11: width of x coordinate and x results.
- `V_WIDTH`, 10: width of y coordinate and y results.
- `ZONES`, 4: number of strips; must be a power of two, ≥1.
- `ZONE_W`, 256: strip width in pixels; must be a power of two.
- `V_MAX`, 768: maximum active lines; sizes the counters.
- `MIN_COUNT`, 64: minimum pixels for a zone to be present.

Ports:
- `clk_in`, input, 1: pixel clock (65 MHz). Single clock domain.
- `rst_in`, input, 1: synchronous, active-high reset.
- `x_in`, input, H_WIDTH: pixel column, already pipeline-aligned with `valid_in`.
- `y_in`, input, V_WIDTH: pixel row.
- `valid_in`, input, 1: pixel passed threshold (mask).
- `tabulate_in`, input, 1: frame boundary. High on the first pixel of a new frame.
- `x_out`, output, ZONES×H_WIDTH: per-zone centroid x.
- `y_out`, output, ZONES×V_WIDTH: per-zone centroid y.
- `present_out`, output, ZONES: per-zone count ≥ `MIN_COUNT`.
- `dominant_out`, output, clog2(ZONES) (min 1): index of the present zone with the largest count.
- `dominant_valid_out`, output, 1: at least one zone is present.
- `valid_out`, output, 1: one-cycle pulse when a new result set is published.
- `busy_out`, output, 1: divider sequence in progress.
- `overrun_out`, output, 1: one-cycle pulse when a frame is dropped.

## Operation
- **Input stage:** `x_in`, `y_in`, `valid_in` and `tabulate_in` are registered once (S1).
- **Zone index:** zone = `x >> log2(ZONE_W)`. Pixels with x ≥ `ZONES*ZONE_W` are ignored.
- **Accumulator widths:**
  - CNT_W = clog2(`ZONE_W*V_MAX`+1).
  - Per zone: live count (CNT_W), sum_x (H_WIDTH+CNT_W), sum_y (V_WIDTH+CNT_W).
  - No saturation is needed at these widths.
- **Snapshot:** when S1 tabulate is high and the FSM is IDLE:
  - Shadow registers take the live accumulators.
  - Live accumulators restart from the S1 pixel: it is counted if valid, otherwise they load 0.
  - The FSM starts.
  - A pixel coincident with `tabulate_in` therefore belongs to the new frame.
- **Tabulate while busy:**
  - Live accumulators are restarted the same way.
  - No snapshot is taken and `overrun_out` pulses.
  - The in-flight result is still published.
- **FSM states:** IDLE → LOAD_X → DIV_X → LOAD_Y → DIV_Y → (next zone: LOAD_X | last zone: PUBLISH) → IDLE.
  - LOAD states take 1 cycle.
  - DIV_X takes H_WIDTH cycles and DIV_Y takes V_WIDTH cycles, one restoring quotient bit per cycle, producing floor(sum/count).
  - Zone order is 0..ZONES-1.
- **Absent zones:** a zone with count < `MIN_COUNT` (including 0) still consumes the full cycle budget. Its results are forced to 0 and `present_out` bit = 0.
- **Dominant zone:** the present zone with the largest count; ties go to the lowest index. With no present zone, `dominant_out`=0 and `dominant_valid_out`=0.
- **Publish:** results are built in a staging set. In PUBLISH, all outputs update together and `valid_out` pulses, so readers never see a mixed frame.
- **Reset:** every output is 0 (`busy_out`=0). Accumulators, shadow and staging registers are 0, and the FSM is IDLE. Reset mid-sequence aborts with no `valid_out`.

## Timing
- `tabulate_in` high in cycle T → snapshot at T+1 edge → `busy_out` high from T+2.
- `valid_out` high in cycle T+L, with L = 3 + ZONES·(H_WIDTH+V_WIDTH+2). Default L = 95.
- `busy_out` drops in the cycle `valid_out` is high.
- Outputs hold between publishes.
- L must be less than the frame period; line blanking is irrelevant because accumulation continues concurrently.

## Structure
- Package `zone_pkg`:
  - FSM state enum (IDLE, LOAD_X, DIV_X, LOAD_Y, DIV_Y, PUBLISH).
  - Localparam helpers for CNT_W and the sum widths.
  - Function for the zone index.
- Sub-module `serial_divider`:
  - Parametrised dividend, divisor and quotient widths.
  - `start`/`done` handshake, fixed latency equal to the quotient width.
  - Instantiated once and shared across all zones and both axes.

## Test plan
1. **Reset:** assert `rst_in` 3 cycles → all outputs 0 and FSM IDLE; then tabulate with no mask pixels → `valid_out` at T+95 with `present_out`=0 and `dominant_valid_out`=0.
2. **Single blob:** 10×10 blob at x 100..109, y 200..209, then tabulate → zone 0 gives x=104, y=204, present=4'b0001; `dominant_out`=0; other zones 0.
3. **Presence threshold:** 8×8 blob at x 300..307, y 10..17 plus 7×9 blob at x 600..606 → zone 1 gives x=303, y=13, present; zone 2 (63 px) absent with outputs 0; `dominant_out`=1.
4. **Boundary pixels:** masked pixels at x=1024..1100 are ignored; a masked pixel coincident with `tabulate_in` appears only in the next frame's count.
5. **Overrun:** second tabulate 20 cycles after the first → `overrun_out` pulses at T+21; first result is still published at T+95; no second `valid_out`.
6. **Reset mid-sequence:** `rst_in` at T+40 → outputs 0, no `valid_out` at T+95, and the next tabulate works normally.
